tbuf_bus_turnaround: RTL and testbench
======================================

// Module: tbuf_bus_turnaround
// PURPOSE
//  Upstream control stage for banks of tbuf cells sharing one tri-state bus.
//  Arbitrates N driver requests round-robin and registers each driver's data onto its tbuf A pins.
//  Generates complementary EN/EN_BAR per bank and enforces break-before-make dead time so two banks never overlap.
//  Lives in the 12T 3v3 library test/IP area, next to the tbuf cells it drives.
// PARAMETERS
//  N_DRV     4   number of driver banks (>=2)
//  W         8   bus width; each bank is W tbuf cells
//  DEAD_CYC  2   all-disabled cycles between grants (>=1)
//  MAX_HOLD  16  max grant length in cycles, used only with TBUF_TIMEOUT_EN (>=1)
// PORTS
//  CLK     in   1        clock, rising edge
//  RST     in   1        synchronous reset, active-high
//  REQ     in   N_DRV    per-bank bus request, level
//  DIN     in   N_DRV*W  per-bank data, slice i = DIN[i*W +: W]
//  A       out  N_DRV*W  registered data to tbuf A pins, same slicing
//  EN      out  N_DRV    tbuf enable, one-hot-or-zero
//  EN_BAR  out  N_DRV    tbuf enable complement, always ~EN
//  GNT     out  N_DRV    grant, equals EN
//  BUSY    out  1        state != IDLE
//  TIMEOUT out  1        1-cycle pulse on forced revoke (0 when feature absent)
// BEHAVIOUR
//  Reset (RST high at edge): state IDLE, EN=0, EN_BAR=all 1s, GNT=0, A=0, BUSY=0, TIMEOUT=0, rr pointer=0.
//  RST overrides everything; asserting it mid-DRIVE clears EN on that edge.
//  A: every slice registered from DIN each cycle, 1-cycle latency, regardless of grant.
//  Grant selection: lowest index >= pointer among set REQ bits, wrapping modulo N_DRV.
//  States:
//   IDLE:  if any REQ, grant g; next edge EN[g]=1 -> DRIVE. Latency REQ->EN = 1 cycle.
//   DRIVE: hold g while REQ[g]=1. On REQ[g]=0: next edge EN=0, pointer=(g+1)%N_DRV, load dead counter -> TURN.
//   TURN:  EN=0 for exactly DEAD_CYC cycles. On the last TURN cycle arbitrate: request -> DRIVE, else IDLE.
//  Consecutive grants are separated by exactly DEAD_CYC EN-low cycles.
//  REQ from other banks during DRIVE/TURN is ignored until arbitration. No preemption except timeout.
//  REQ[g] re-rising during TURN gets no special priority; pointer already advanced past g.
//  Dead counter width $clog2(DEAD_CYC+1); it saturates at 0 and never wraps.
//  Invariants, all cycles: EN & EN_BAR == 0; EN | EN_BAR == all 1s; $onehot0(EN); GNT == EN.
//  EN, EN_BAR, GNT come straight from flops; no combinational path from REQ.
// CONFIGURATION
//  TBUF_TIMEOUT_EN defined:
//   Hold counter runs in DRIVE. When REQ[g] is still high after MAX_HOLD cycles, grant is revoked as for a REQ drop.
//   TIMEOUT pulses high for the cycle EN falls; pointer advances past g.
//  Not defined: no hold counter, grants are unbounded, TIMEOUT tied 0, MAX_HOLD ignored.
// TESTING (N_DRV=4, W=8, DEAD_CYC=2, MAX_HOLD=16)
//  Reset: RST 1 for 2 cycles with REQ=4'hF -> EN=0, EN_BAR=4'hF, A=0, BUSY=0 throughout.
//  Single grant: REQ=4'b0100, DIN slice2=8'hA5 -> next edge EN=4'b0100, EN_BAR=4'b1011, A slice2=8'hA5.
//  Turnaround: REQ 4'b0011 with bank0 granted, drop REQ[0] -> EN=0 for exactly 2 cycles, then EN=4'b0010.
//  Round-robin: REQ=4'hF held, each bank drops after 3 cycles -> grant order 0,1,2,3,0.
//  Mid-op reset: RST pulsed during DRIVE -> EN=0 and EN_BAR=4'hF on that edge, pointer=0.
//  Timeout (macro on): REQ[1] held 40 cycles -> EN[1] high 16 cycles, TIMEOUT 1 pulse, 2 dead cycles, regrant.

Source files
------------

// File: rtl/tbuf_bus_turnaround.sv
// Round-robin tri-state bus arbiter with break-before-make dead time.
// Define TBUF_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module tbuf_bus_turnaround #(
  parameter int N_DRV    = 4,
  parameter int W        = 8,
  parameter int DEAD_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_DRV-1:0]   REQ,
  input  logic [N_DRV*W-1:0] DIN,
  output logic [N_DRV*W-1:0] A,
  output logic [N_DRV-1:0]   EN,
  output logic [N_DRV-1:0]   EN_BAR,
  output logic [N_DRV-1:0]   GNT,
  output logic               BUSY,
  output logic               TIMEOUT
);

  localparam int PW = (N_DRV > 1) ? $clog2(N_DRV) : 1;
  localparam int DW = $clog2(DEAD_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    g;
  logic [PW-1:0]    g_inc;
  logic [DW-1:0]    dead;
  logic [PW-1:0]    pick;
  logic [N_DRV-1:0] pick_oh;
  logic             any;
  logic             expire;
  logic             rel;
  int               idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = 0; k < N_DRV; k++) begin
      idx = (int'(ptr) + k) % N_DRV;
      if (!any && REQ[idx[PW-1:0]]) begin
        pick = idx[PW-1:0];
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  assign g_inc = (g == PW'(N_DRV - 1)) ? '0 : g + 1'b1;
  assign rel   = !REQ[g] || expire;
  assign GNT   = EN;

`ifdef TBUF_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold;
  logic          to_q;

  assign expire  = (hold == HW'(MAX_HOLD));
  assign TIMEOUT = to_q;

  // hold reads 1 on the first DRIVE cycle, so a grant lasts MAX_HOLD cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold <= HW'(1);
      to_q <= 1'b0;
    end else begin
      hold <= (state == DRIVE && !rel) ? hold + 1'b1 : HW'(1);
      to_q <= (state == DRIVE) && expire && REQ[g];
    end
  end
`else
  assign expire  = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      A <= '0;
    end else begin
      A <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      EN     <= '0;
      EN_BAR <= '1;
      BUSY   <= 1'b0;
      ptr    <= '0;
      g      <= '0;
      dead   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state  <= DRIVE;
            EN     <= pick_oh;
            EN_BAR <= ~pick_oh;
            g      <= pick;
            BUSY   <= 1'b1;
          end
        end
        DRIVE: begin
          if (rel) begin
            state  <= TURN;
            EN     <= '0;
            EN_BAR <= '1;
            ptr    <= g_inc;
            dead   <= DW'(DEAD_CYC);
          end
        end
        TURN: begin
          dead <= (dead != '0) ? dead - 1'b1 : '0;
          // Last dead cycle: next edge may already drive again.
          if (dead <= DW'(1)) begin
            if (any) begin
              state  <= DRIVE;
              EN     <= pick_oh;
              EN_BAR <= ~pick_oh;
              g      <= pick;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          EN     <= '0;
          EN_BAR <= '1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbuf_bus_turnaround.sv
// Directed bench for tbuf_bus_turnaround (N_DRV=4, W=8, DEAD_CYC=2).
// Honours TBUF_TIMEOUT_EN the same way as the design.
module tb_tbuf_bus_turnaround;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [31:0] a;
  logic [3:0]  en;
  logic [3:0]  en_bar;
  logic [3:0]  gnt;
  logic        busy;
  logic        tmo;

  int n_chk;
  int n_fail;
  bit run_inv;

  tbuf_bus_turnaround #(
    .N_DRV(4), .W(8), .DEAD_CYC(2), .MAX_HOLD(16)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .DIN(din),
    .A(a), .EN(en), .EN_BAR(en_bar), .GNT(gnt),
    .BUSY(busy), .TIMEOUT(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants every cycle once out of power-up.
  always @(negedge clk) begin
    if (run_inv) begin
      n_chk++;
      if ((en & en_bar) !== 4'h0 || (en | en_bar) !== 4'hF ||
          !$onehot0(en) || gnt !== en) begin
        n_fail++;
        $display("FAIL invariant en=%b en_bar=%b gnt=%b", en, en_bar, gnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'hF;
    din = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      run_inv = 1'b1;
      n_chk++;
      if (en !== 4'h0 || en_bar !== 4'hF || a !== 32'h0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset en=%b en_bar=%b a=%h busy=%b want 0000 1111 0 0",
                 en, en_bar, a, busy);
      end
    end
    rst = 1'b0;
    req = 4'h0;
    tick();
    n_chk++;
    if (busy !== 1'b0 || en !== 4'h0 || a !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL post_reset busy=%b en=%b a=%h want 0 0000 deadbeef",
               busy, en, a);
    end
  endtask

  task automatic test_single();
    din = 32'h12A5_3456;
    req = 4'b0100;
    tick();
    n_chk++;
    if (en !== 4'b0100 || en_bar !== 4'b1011 || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_en en=%b en_bar=%b gnt=%b want 0100 1011 0100",
               en, en_bar, gnt);
    end
    n_chk++;
    if (a[23:16] !== 8'hA5 || a !== 32'h12A5_3456 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_data a=%h busy=%b want 12a53456 1", a, busy);
    end
    req = 4'b0000;
    tick();
    tick();
    n_chk++;
    if (en !== 4'h0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_turn en=%b busy=%b want 0000 1", en, busy);
    end
    tick();
    n_chk++;
    if (en !== 4'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle en=%b busy=%b want 0000 0", en, busy);
    end
  endtask

  // Pointer sits at 3 here, so bank0 wins the wrap.
  task automatic test_turnaround();
    req = 4'b0011;
    tick();
    n_chk++;
    if (en !== 4'b0001) begin
      n_fail++;
      $display("FAIL ta_first en=%b want 0001", en);
    end
    tick();
    tick();
    n_chk++;
    if (en !== 4'b0001) begin
      n_fail++;
      $display("FAIL ta_hold en=%b want 0001", en);
    end
    req = 4'b0010;
    tick();
    n_chk++;
    if (en !== 4'b0000) begin
      n_fail++;
      $display("FAIL ta_dead1 en=%b want 0000", en);
    end
    tick();
    n_chk++;
    if (en !== 4'b0000) begin
      n_fail++;
      $display("FAIL ta_dead2 en=%b want 0000", en);
    end
    tick();
    n_chk++;
    if (en !== 4'b0010 || en_bar !== 4'b1101) begin
      n_fail++;
      $display("FAIL ta_next en=%b en_bar=%b want 0010 1101", en, en_bar);
    end
    req = 4'b0000;
    repeat (4) tick();
  endtask

  // Pointer is 2 before this grant; reset must bring it back to 0.
  task automatic test_mid_reset();
    req = 4'b0100;
    tick();
    n_chk++;
    if (en !== 4'b0100) begin
      n_fail++;
      $display("FAIL mr_grant en=%b want 0100", en);
    end
    tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if (en !== 4'h0 || en_bar !== 4'hF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_clear en=%b en_bar=%b busy=%b want 0000 1111 0",
               en, en_bar, busy);
    end
    rst = 1'b0;
    req = 4'h0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    int b;
    int gap;
    int order [5] = '{0, 1, 2, 3, 0};
    req = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      b = order[i];
      exp_oh = 4'b0001 << b;
      n_chk++;
      if (en !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_grant%0d en=%b want %b", i, en, exp_oh);
      end
      tick();
      tick();
      req[b] = 1'b0;
      tick();
      n_chk++;
      if (en !== 4'h0) begin
        n_fail++;
        $display("FAIL rr_drop%0d en=%b want 0000", i, en);
      end
      if (i == 4) begin
        req = 4'h0;
        tick();
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_idle busy=%b want 0", busy);
        end
      end else begin
        req[b] = 1'b1;
        gap = 1;
        tick();
        while (en === 4'h0 && gap < 10) begin
          gap++;
          tick();
        end
        n_chk++;
        if (gap != 2) begin
          n_fail++;
          $display("FAIL rr_gap%0d dead=%0d want 2", i, gap);
        end
      end
    end
  endtask

`ifdef TBUF_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    req = 4'b0010;
    tick();
    hi = 1;
    n_chk++;
    if (en !== 4'b0010 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL to_grant en=%b tmo=%b want 0010 0", en, tmo);
    end
    tick();
    while (en[1] === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    n_chk++;
    if (hi != 16) begin
      n_fail++;
      $display("FAIL to_len high=%0d want 16", hi);
    end
    n_chk++;
    if (tmo !== 1'b1 || en !== 4'h0) begin
      n_fail++;
      $display("FAIL to_pulse tmo=%b en=%b want 1 0000", tmo, en);
    end
    tick();
    n_chk++;
    if (tmo !== 1'b0 || en !== 4'h0) begin
      n_fail++;
      $display("FAIL to_dead tmo=%b en=%b want 0 0000", tmo, en);
    end
    tick();
    n_chk++;
    if (en !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_regrant en=%b want 0010", en);
    end
    req = 4'h0;
    repeat (4) tick();
  endtask
`else
  task automatic test_timeout();
    int bad;
    req = 4'b0010;
    tick();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (en !== 4'b0010 || tmo !== 1'b0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_timeout bad_cycles=%0d want 0", bad);
    end
    req = 4'h0;
    repeat (4) tick();
  endtask
`endif

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    run_inv = 1'b0;
    rst     = 1'b1;
    req     = 4'h0;
    din     = 32'h0;
    test_reset();
    test_single();
    test_turnaround();
    test_mid_reset();
    test_round_robin();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
